// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: instruction formats, opcodes and the ID/EX register layout.
// ID_ILLEGAL_TRAP_EN adds an illegal-instruction flag to the ID/EX register.
package riscv_pkg;

   localparam int unsigned Xlen  = 32;
   localparam int unsigned RegAw = 5;

   localparam logic [6:0] OpcodeOp     = 7'b0110011;
   localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
   localparam logic [6:0] OpcodeLoad   = 7'b0000011;
   localparam logic [6:0] OpcodeJalr   = 7'b1100111;
   localparam logic [6:0] OpcodeStore  = 7'b0100011;
   localparam logic [6:0] OpcodeBranch = 7'b1100011;
   localparam logic [6:0] OpcodeLui    = 7'b0110111;
   localparam logic [6:0] OpcodeAuipc  = 7'b0010111;
   localparam logic [6:0] OpcodeJal    = 7'b1101111;

   typedef enum logic [2:0] {
      TYPE_R,
      TYPE_I,
      TYPE_S,
      TYPE_B,
      TYPE_U,
      TYPE_J,
      TYPE_ILLEGAL
   } inst_type_e;

   typedef struct packed {
      logic            valid;
      logic [Xlen-1:0] pc;
      logic [Xlen-1:0] rs1_data;
      logic [Xlen-1:0] rs2_data;
      logic [Xlen-1:0] imm;
      logic [RegAw-1:0] rd_addr;
      logic            rd_valid;
      inst_type_e      op_type;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            mem_read;
`ifdef ID_ILLEGAL_TRAP_EN
      logic            illegal;
`endif
   } id_ex_t;

   function automatic inst_type_e decode_type(input logic [6:0] opcode);
      inst_type_e t;
      case (opcode)
         OpcodeOp:                             t = TYPE_R;
         OpcodeOpImm, OpcodeLoad, OpcodeJalr:  t = TYPE_I;
         OpcodeStore:                          t = TYPE_S;
         OpcodeBranch:                         t = TYPE_B;
         OpcodeLui, OpcodeAuipc:               t = TYPE_U;
         OpcodeJal:                            t = TYPE_J;
         default:                              t = TYPE_ILLEGAL;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: sign-extends the immediate of the given format.
// R-type and illegal encodings produce zero.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int unsigned DataWidth = 32
) (
   input  logic [31:7]          i_instr,
   input  inst_type_e           i_type,
   output logic [DataWidth-1:0] o_imm
);

   always_comb begin
      o_imm = '0;
      case (i_type)
         TYPE_I: o_imm = {{(DataWidth-11){i_instr[31]}}, i_instr[30:20]};
         TYPE_S: o_imm = {{(DataWidth-11){i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
         TYPE_B: o_imm = {{(DataWidth-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                          i_instr[11:8], 1'b0};
         TYPE_U: o_imm = {{(DataWidth-31){i_instr[31]}}, i_instr[30:12], 12'b0};
         TYPE_J: o_imm = {{(DataWidth-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                          i_instr[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes IF/ID, drives register-file reads and fills the ID/EX register.
// Define ID_ILLEGAL_TRAP_EN to flag illegal opcodes on ex_illegal_o instead of issuing a NOP.
module id_stage
   import riscv_pkg::*;
#(
   parameter  int unsigned DataWidth  = 32,
   parameter  int unsigned NumEntries = 31,
   localparam int unsigned RegAddrW   = $clog2(NumEntries)
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 if_valid_i,
   output logic                 if_ready_o,
   input  logic [31:0]          if_instr_i,
   input  logic [DataWidth-1:0] if_pc_i,
   input  logic                 flush_i,
   output logic                 rs1_valid_o,
   output logic                 rs2_valid_o,
   output logic [RegAddrW-1:0]  rs1_addr_o,
   output logic [RegAddrW-1:0]  rs2_addr_o,
   input  logic [DataWidth-1:0] rs1_data_i,
   input  logic [DataWidth-1:0] rs2_data_i,
   output logic                 ex_valid_o,
   input  logic                 ex_ready_i,
   output logic [DataWidth-1:0] ex_pc_o,
   output logic [DataWidth-1:0] ex_rs1_data_o,
   output logic [DataWidth-1:0] ex_rs2_data_o,
   output logic [DataWidth-1:0] ex_imm_o,
   output logic [RegAddrW-1:0]  ex_rd_addr_o,
   output logic                 ex_rd_valid_o,
   output inst_type_e           ex_op_type_o,
   output logic [2:0]           ex_funct3_o,
   output logic                 ex_funct7b5_o,
`ifdef ID_ILLEGAL_TRAP_EN
   output logic                 ex_illegal_o,
`endif
   output logic                 ex_mem_read_o
);

   logic [6:0]           w_opcode;
   logic [4:0]           w_rs1;
   logic [4:0]           w_rs2;
   logic [4:0]           w_rd;
   inst_type_e           w_type;
   logic                 w_use_rs1;
   logic                 w_use_rs2;
   logic                 w_use_rd;
   logic                 w_rs1_valid;
   logic                 w_rs2_valid;
   logic                 w_rd_valid;
   logic                 w_mem_read;
   logic [DataWidth-1:0] w_imm;
   logic                 w_advance;
   logic                 w_hazard;
   id_ex_t               w_dec;
   id_ex_t               w_bubble;
   id_ex_t               w_next;
   id_ex_t               r_id_ex;

   assign w_opcode = if_instr_i[6:0];
   assign w_rs1    = if_instr_i[19:15];
   assign w_rs2    = if_instr_i[24:20];
   assign w_rd     = if_instr_i[11:7];
   assign w_type   = decode_type(w_opcode);

   always_comb begin
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_use_rd  = 1'b0;
      case (w_type)
         TYPE_R: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_use_rd  = 1'b1;
         end
         TYPE_I: begin
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
         end
         TYPE_S, TYPE_B: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
         end
         TYPE_U, TYPE_J: w_use_rd = 1'b1;
         default: ;
      endcase
   end

   // x0 is never read or written: its valids drop and the operand is forced to zero below
   assign w_rs1_valid = if_valid_i & w_use_rs1 & (w_rs1 != 5'd0);
   assign w_rs2_valid = if_valid_i & w_use_rs2 & (w_rs2 != 5'd0);
   assign w_rd_valid  = if_valid_i & w_use_rd & (w_rd != 5'd0);
   assign w_mem_read  = if_valid_i & (w_opcode == OpcodeLoad);

   assign rs1_valid_o = w_rs1_valid;
   assign rs2_valid_o = w_rs2_valid;
   assign rs1_addr_o  = RegAddrW'(w_rs1);
   assign rs2_addr_o  = RegAddrW'(w_rs2);

   imm_gen #(
      .DataWidth (DataWidth)
   ) u_imm_gen (
      .i_instr (if_instr_i[31:7]),
      .i_type  (w_type),
      .o_imm   (w_imm)
   );

   assign w_advance = ~r_id_ex.valid | ex_ready_i;
   assign w_hazard  = r_id_ex.valid & r_id_ex.mem_read & r_id_ex.rd_valid &
                      ((w_rs1_valid & (w_rs1 == r_id_ex.rd_addr)) |
                       (w_rs2_valid & (w_rs2 == r_id_ex.rd_addr)));

   assign if_ready_o = flush_i | (w_advance & ~w_hazard);

   always_comb begin
      w_dec          = '0;
      w_dec.valid    = 1'b1;
      w_dec.pc       = if_pc_i;
      w_dec.rs1_data = w_rs1_valid ? rs1_data_i : '0;
      w_dec.rs2_data = w_rs2_valid ? rs2_data_i : '0;
      w_dec.imm      = w_imm;
      w_dec.rd_addr  = w_rd;
      w_dec.rd_valid = w_rd_valid;
      w_dec.op_type  = w_type;
      w_dec.funct3   = if_instr_i[14:12];
      w_dec.funct7b5 = if_instr_i[30];
      w_dec.mem_read = w_mem_read;
`ifdef ID_ILLEGAL_TRAP_EN
      w_dec.illegal  = (w_type == TYPE_ILLEGAL);
`endif
   end

   // Bubbles keep the stale data fields; only the qualifying bits are cleared
   always_comb begin
      w_bubble          = r_id_ex;
      w_bubble.valid    = 1'b0;
      w_bubble.rd_valid = 1'b0;
      w_bubble.mem_read = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      w_bubble.illegal  = 1'b0;
`endif
      if (flush_i) begin
         w_next = w_bubble;
      end else if (!w_advance) begin
         w_next = r_id_ex;
      end else if (w_hazard) begin
         w_next = w_bubble;
      end else if (if_valid_i) begin
         w_next = w_dec;
      end else begin
         w_next = w_bubble;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_id_ex <= '0;
      end else begin
         r_id_ex <= w_next;
      end
   end

   assign ex_valid_o    = r_id_ex.valid;
   assign ex_pc_o       = r_id_ex.pc;
   assign ex_rs1_data_o = r_id_ex.rs1_data;
   assign ex_rs2_data_o = r_id_ex.rs2_data;
   assign ex_imm_o      = r_id_ex.imm;
   assign ex_rd_addr_o  = r_id_ex.rd_addr;
   assign ex_rd_valid_o = r_id_ex.rd_valid;
   assign ex_op_type_o  = r_id_ex.op_type;
   assign ex_funct3_o   = r_id_ex.funct3;
   assign ex_funct7b5_o = r_id_ex.funct7b5;
   assign ex_mem_read_o = r_id_ex.mem_read;
`ifdef ID_ILLEGAL_TRAP_EN
   assign ex_illegal_o  = r_id_ex.illegal;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed RV32I vectors against a decode-level model.
// Honours ID_ILLEGAL_TRAP_EN the same way as the design.
module tb_id_stage;
   import riscv_pkg::*;

   localparam logic [31:0] InsAddi    = 32'h0070_0293;  // addi x5,x0,7
   localparam logic [31:0] InsAdd     = 32'h0020_81B3;  // add  x3,x1,x2
   localparam logic [31:0] InsLw      = 32'h0000_A203;  // lw   x4,0(x1)
   localparam logic [31:0] InsAddUse  = 32'h0022_0333;  // add  x6,x4,x2
   localparam logic [31:0] InsSub     = 32'h4011_83B3;  // sub  x7,x3,x1
   localparam logic [31:0] InsSw      = 32'h0020_A423;  // sw   x2,8(x1)
   localparam logic [31:0] InsBeq     = 32'hFE20_8EE3;  // beq  x1,x2,-4
   localparam logic [31:0] InsLui     = 32'h1234_5437;  // lui  x8,0x12345
   localparam logic [31:0] InsJal     = 32'h0100_00EF;  // jal  x1,16
   localparam logic [31:0] InsAddiNeg = 32'hFFF0_8493;  // addi x9,x1,-1
   localparam logic [31:0] InsAddX0   = 32'h0020_8033;  // add  x0,x1,x2
   localparam logic [31:0] InsIllegal = 32'h0000_007F;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        if_valid_i = 1'b0;
   logic        if_ready_o;
   logic [31:0] if_instr_i = '0;
   logic [31:0] if_pc_i = '0;
   logic        flush_i = 1'b0;
   logic        rs1_valid_o;
   logic        rs2_valid_o;
   logic [4:0]  rs1_addr_o;
   logic [4:0]  rs2_addr_o;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic        ex_valid_o;
   logic        ex_ready_i = 1'b0;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_rs1_data_o;
   logic [31:0] ex_rs2_data_o;
   logic [31:0] ex_imm_o;
   logic [4:0]  ex_rd_addr_o;
   logic        ex_rd_valid_o;
   inst_type_e  ex_op_type_o;
   logic [2:0]  ex_funct3_o;
   logic        ex_funct7b5_o;
   logic        ex_mem_read_o;
`ifdef ID_ILLEGAL_TRAP_EN
   logic        ex_illegal_o;
`endif

   always #5 clk_i = ~clk_i;

   id_stage dut (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .if_valid_i    (if_valid_i),
      .if_ready_o    (if_ready_o),
      .if_instr_i    (if_instr_i),
      .if_pc_i       (if_pc_i),
      .flush_i       (flush_i),
      .rs1_valid_o   (rs1_valid_o),
      .rs2_valid_o   (rs2_valid_o),
      .rs1_addr_o    (rs1_addr_o),
      .rs2_addr_o    (rs2_addr_o),
      .rs1_data_i    (rs1_data_i),
      .rs2_data_i    (rs2_data_i),
      .ex_valid_o    (ex_valid_o),
      .ex_ready_i    (ex_ready_i),
      .ex_pc_o       (ex_pc_o),
      .ex_rs1_data_o (ex_rs1_data_o),
      .ex_rs2_data_o (ex_rs2_data_o),
      .ex_imm_o      (ex_imm_o),
      .ex_rd_addr_o  (ex_rd_addr_o),
      .ex_rd_valid_o (ex_rd_valid_o),
      .ex_op_type_o  (ex_op_type_o),
      .ex_funct3_o   (ex_funct3_o),
      .ex_funct7b5_o (ex_funct7b5_o),
`ifdef ID_ILLEGAL_TRAP_EN
      .ex_illegal_o  (ex_illegal_o),
`endif
      .ex_mem_read_o (ex_mem_read_o)
   );

   // Register file; x0 holds garbage so the design's own x0 forcing is exercised
   logic [31:0] regs [32];
   assign rs1_data_i = regs[rs1_addr_o];
   assign rs2_data_i = regs[rs2_addr_o];

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rdv;
      logic [2:0]  typ;
      logic [2:0]  f3;
      logic        f7;
      logic        mr;
      logic        ill;
      logic        u1;
      logic        u2;
      logic        rs1v;
      logic        rs2v;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } mdl_t;

   mdl_t        m;
   mdl_t        m_next;
   logic        e_rs1v, e_rs2v, e_ready, e_ready_chk;
   logic [4:0]  e_rs1a, e_rs2a;
   logic        chk_en = 1'b0;
   logic [31:0] pc_cnt = 32'h0000_1000;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic mdl_t reset_m();
      mdl_t r;
      r = '{default: '0};
      return r;
   endfunction

   function automatic mdl_t bubble(input mdl_t x);
      mdl_t b;
      b       = x;
      b.valid = 1'b0;
      b.rdv   = 1'b0;
      b.mr    = 1'b0;
      b.ill   = 1'b0;
      return b;
   endfunction

   // What the ID/EX register must hold for instruction ins, straight from the RV32I formats
   function automatic mdl_t decode(input logic [31:0] ins, input logic [31:0] pc);
      mdl_t        d;
      logic        wr;
      logic [31:0] sgn;
      d     = '{default: '0};
      wr    = 1'b0;
      sgn   = 32'($signed(ins) >>> 31);
      d.typ = TYPE_ILLEGAL;
      case (ins[6:0])
         7'h33:               begin d.typ = TYPE_R; d.u1 = 1; d.u2 = 1; wr = 1; end
         7'h13, 7'h03, 7'h67: begin d.typ = TYPE_I; d.u1 = 1; wr = 1; end
         7'h23:               begin d.typ = TYPE_S; d.u1 = 1; d.u2 = 1; end
         7'h63:               begin d.typ = TYPE_B; d.u1 = 1; d.u2 = 1; end
         7'h37, 7'h17:        begin d.typ = TYPE_U; wr = 1; end
         7'h6F:               begin d.typ = TYPE_J; wr = 1; end
         default: ;
      endcase
      case (d.typ)
         TYPE_I:  d.imm = 32'($signed(ins) >>> 20);
         TYPE_S:  d.imm = (sgn << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
         TYPE_B:  d.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
                          (32'(ins[11:8]) << 1);
         TYPE_U:  d.imm = ins & 32'hFFFF_F000;
         TYPE_J:  d.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
                          (32'(ins[30:21]) << 1);
         default: d.imm = 32'h0;
      endcase
      d.rs1   = ins[19:15];
      d.rs2   = ins[24:20];
      d.rd    = ins[11:7];
      d.rs1v  = d.u1 && (d.rs1 != 0);
      d.rs2v  = d.u2 && (d.rs2 != 0);
      d.rs1d  = d.rs1v ? regs[d.rs1] : 32'h0;
      d.rs2d  = d.rs2v ? regs[d.rs2] : 32'h0;
      d.rdv   = wr && (d.rd != 0);
      d.mr    = (ins[6:0] == 7'h03);
      d.f3    = ins[14:12];
      d.f7    = ins[30];
      d.pc    = pc;
      d.valid = 1'b1;
`ifdef ID_ILLEGAL_TRAP_EN
      d.ill   = (d.typ == TYPE_ILLEGAL);
`endif
      return d;
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
      mdl_t d;
      logic adv, haz;
      if_valid_i = v;
      if_instr_i = ins;
      if_pc_i    = pc_cnt;
      pc_cnt     = pc_cnt + 4;
      ex_ready_i = rdy;
      flush_i    = fl;
      d          = decode(ins, if_pc_i);
      e_rs1v     = v && d.rs1v;
      e_rs2v     = v && d.rs2v;
      e_rs1a     = d.rs1;
      e_rs2a     = d.rs2;
      adv        = !m.valid || rdy;
      haz        = m.valid && m.mr && m.rdv &&
                   ((e_rs1v && d.rs1 == m.rd) || (e_rs2v && d.rs2 == m.rd));
      e_ready     = fl || (adv && !haz);
      e_ready_chk = v || fl;
      if (fl)          m_next = bubble(m);
      else if (!adv)   m_next = m;
      else if (haz)    m_next = bubble(m);
      else if (v)      m_next = d;
      else             m_next = bubble(m);
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (!reset_ni) m = reset_m();
      else           m = m_next;
      #1;
   endtask

   always @(negedge clk_i) begin
      if (chk_en) begin
         check("ex_valid", ex_valid_o, m.valid);
         check("ex_rd_valid", ex_rd_valid_o, m.rdv);
         check("ex_mem_read", ex_mem_read_o, m.mr);
`ifdef ID_ILLEGAL_TRAP_EN
         check("ex_illegal", ex_illegal_o, m.ill);
`endif
         if (m.valid) begin
            check("ex_pc", ex_pc_o, m.pc);
            check("ex_imm", ex_imm_o, m.imm);
            check("ex_op_type", ex_op_type_o, m.typ);
            check("ex_funct3", ex_funct3_o, m.f3);
            check("ex_funct7b5", ex_funct7b5_o, m.f7);
            if (m.rdv) check("ex_rd_addr", ex_rd_addr_o, m.rd);
            if (m.u1)  check("ex_rs1_data", ex_rs1_data_o, m.rs1d);
            if (m.u2)  check("ex_rs2_data", ex_rs2_data_o, m.rs2d);
         end
         check("rs1_valid", rs1_valid_o, e_rs1v);
         check("rs2_valid", rs2_valid_o, e_rs2v);
         if (e_rs1v) check("rs1_addr", rs1_addr_o, e_rs1a);
         if (e_rs2v) check("rs2_addr", rs2_addr_o, e_rs2a);
         if (e_ready_chk) check("if_ready", if_ready_o, e_ready);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 10);
      regs[0] = 32'hDEAD_BEEF;
      m = reset_m();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      m_next = reset_m();
      chk_en = 1'b1;
      tick();
      tick();
      check("reset_op_type", ex_op_type_o, TYPE_R);
      check("reset_pc", ex_pc_o, 32'h0);
      check("reset_imm", ex_imm_o, 32'h0);
      check("reset_valid", ex_valid_o, 1'b0);
      reset_ni = 1'b1;

      // addi x5,x0,7
      drive(1'b1, InsAddi, 1'b1, 1'b0);
      #1 check("addi_rs1_valid", rs1_valid_o, 1'b0);
      tick();
      check("addi_valid", ex_valid_o, 1'b1);
      check("addi_imm", ex_imm_o, 32'd7);
      check("addi_rd", ex_rd_addr_o, 5'd5);
      check("addi_rs1_data", ex_rs1_data_o, 32'd0);

      // add x3,x1,x2
      drive(1'b1, InsAdd, 1'b1, 1'b0);
      #1 check("add_rs1_addr", rs1_addr_o, 5'd1);
      check("add_rs2_addr", rs2_addr_o, 5'd2);
      tick();
      check("add_rs1_data", ex_rs1_data_o, 32'd10);
      check("add_rs2_data", ex_rs2_data_o, 32'd20);
      check("add_op_type", ex_op_type_o, TYPE_R);

      // Load-use: exactly one bubble
      drive(1'b1, InsLw, 1'b1, 1'b0);
      tick();
      check("lw_mem_read", ex_mem_read_o, 1'b1);
      drive(1'b1, InsAddUse, 1'b1, 1'b0);
      #1 check("lu_hold_ready", if_ready_o, 1'b0);
      tick();
      check("lu_bubble", ex_valid_o, 1'b0);
      drive(1'b1, InsAddUse, 1'b1, 1'b0);
      #1 check("lu_reissue_ready", if_ready_o, 1'b1);
      tick();
      check("lu_issue_valid", ex_valid_o, 1'b1);
      check("lu_issue_rd", ex_rd_addr_o, 5'd6);
      check("lu_issue_rs1", ex_rs1_data_o, 32'd40);

      // EX back-pressure for 3 cycles
      drive(1'b1, InsSub, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, InsSw, 1'b0, 1'b0);
         #1 check("stall_ready", if_ready_o, 1'b0);
         tick();
         check("stall_rd", ex_rd_addr_o, 5'd7);
         check("stall_f7b5", ex_funct7b5_o, 1'b1);
      end
      drive(1'b1, InsSw, 1'b1, 1'b0);
      #1 check("release_ready", if_ready_o, 1'b1);
      tick();
      check("sw_imm", ex_imm_o, 32'd8);
      check("sw_op_type", ex_op_type_o, TYPE_S);

      // Flush during a stall
      drive(1'b1, InsBeq, 1'b0, 1'b0);
      tick();
      drive(1'b1, InsBeq, 1'b0, 1'b1);
      #1 check("flush_ready", if_ready_o, 1'b1);
      tick();
      check("flush_valid", ex_valid_o, 1'b0);

      // Remaining formats, a load with no dependency, and rd = x0
      drive(1'b1, InsBeq, 1'b1, 1'b0);
      tick();
      check("beq_imm", ex_imm_o, 32'hFFFF_FFFC);
      drive(1'b1, InsLui, 1'b1, 1'b0);
      tick();
      check("lui_imm", ex_imm_o, 32'h1234_5000);
      drive(1'b1, InsJal, 1'b1, 1'b0);
      tick();
      check("jal_imm", ex_imm_o, 32'd16);
      drive(1'b1, InsLw, 1'b1, 1'b0);
      tick();
      drive(1'b1, InsAddiNeg, 1'b1, 1'b0);
      #1 check("nodep_ready", if_ready_o, 1'b1);
      tick();
      check("addineg_imm", ex_imm_o, 32'hFFFF_FFFF);
      drive(1'b1, InsAddX0, 1'b1, 1'b0);
      tick();
      check("x0_rd_valid", ex_rd_valid_o, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      check("idle_bubble", ex_valid_o, 1'b0);

      // Illegal opcode
      drive(1'b1, InsIllegal, 1'b1, 1'b0);
      #1 check("ill_rs1_valid", rs1_valid_o, 1'b0);
      tick();
      check("ill_valid", ex_valid_o, 1'b1);
      check("ill_rd_valid", ex_rd_valid_o, 1'b0);
`ifdef ID_ILLEGAL_TRAP_EN
      check("ill_flag", ex_illegal_o, 1'b1);
`endif

      // Asynchronous reset mid-run
      drive(1'b1, InsLui, 1'b1, 1'b0);
      tick();
      reset_ni = 1'b0;
      m = reset_m();
      #1 check("async_reset_valid", ex_valid_o, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      reset_ni = 1'b1;
      drive(1'b1, InsAdd, 1'b1, 1'b0);
      tick();
      check("post_reset_rs2", ex_rs2_data_o, 32'd20);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
